// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer.
// Owns the 128-bit cipher state, performs AddRoundKey itself and drives the
// external SubBytes / ShiftRows / MixColumns units through a one-cycle
// ena / level done handshake. Round keys are fetched by index (key_round).
// Optional feature macro: DONE_TIMEOUT_EN -- aborts a unit wait after
// TIMEOUT cycles without done and raises a sticky error flag.
module aes_round_ctrl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic [3:0]   key_round,
  input  logic [127:0] round_key,
  output logic [127:0] unit_state,
  output logic         sub_ena,
  output logic         shift_ena,
  output logic         mix_ena,
  input  logic [127:0] sub_out,
  input  logic [127:0] shift_out,
  input  logic [127:0] mix_out,
  input  logic         sub_done,
  input  logic         shift_done,
  input  logic         mix_done,
  output logic [127:0] ciphertext,
  output logic         ct_valid,
  output logic         error
);

  typedef enum logic [3:0] {
    IDLE,
    ARK,
    SUB_REQ,
    SUB_WAIT,
    SR_REQ,
    SR_WAIT,
    MC_REQ,
    MC_WAIT,
    FIN
  } fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_t         fsm_q,   fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q,    ct_d;

`ifdef DONE_TIMEOUT_EN
  // Wait-cycle counter only needs to reach TIMEOUT-1 before firing.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          in_wait;
  logic          unit_done;

  // Done of whichever unit is currently being waited on.
  always_comb begin
    in_wait   = (fsm_q == SUB_WAIT) || (fsm_q == SR_WAIT) || (fsm_q == MC_WAIT);
    unit_done = ((fsm_q == SUB_WAIT) && sub_done)   ||
                ((fsm_q == SR_WAIT)  && shift_done) ||
                ((fsm_q == MC_WAIT)  && mix_done);
  end
`endif

  // Next-state logic: round sequencing, state updates and unit handshakes.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
`ifdef DONE_TIMEOUT_EN
    tmo_d   = '0;
    err_d   = err_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = plaintext;
          round_d = 4'd0;
          fsm_d   = ARK;
        end
      end
      ARK: begin
        state_d = state_q ^ round_key;
        if (round_q == LAST_RND) begin
          // Capture here so ciphertext is already valid during the FIN pulse.
          ct_d  = state_q ^ round_key;
          fsm_d = FIN;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = SUB_REQ;
        end
      end
      SUB_REQ: fsm_d = SUB_WAIT;
      SUB_WAIT: begin
        if (sub_done) begin
          state_d = sub_out;
          fsm_d   = SR_REQ;
        end
      end
      SR_REQ: fsm_d = SR_WAIT;
      SR_WAIT: begin
        if (shift_done) begin
          state_d = shift_out;
          // Final round skips MixColumns.
          fsm_d   = (round_q == LAST_RND) ? ARK : MC_REQ;
        end
      end
      MC_REQ: fsm_d = MC_WAIT;
      MC_WAIT: begin
        if (mix_done) begin
          state_d = mix_out;
          fsm_d   = ARK;
        end
      end
      FIN:     fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
`ifdef DONE_TIMEOUT_EN
    // Counter is zero in every non-wait state, so each REQ restarts it.
    // Firing at TIMEOUT-1 means the count would reach TIMEOUT on this edge.
    if (in_wait && !unit_done) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        fsm_d = IDLE;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
    end
  end

`ifdef DONE_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Parameter sanity: round counter is 4 bits, timeout must be non-zero.
  always_ff @(posedge clk) begin
    if (rst) assert (NR >= 1 && NR <= 15 && TIMEOUT >= 1);
  end

  assign busy       = (fsm_q != IDLE);
  assign key_round  = round_q;
  assign unit_state = state_q;
  assign sub_ena    = (fsm_q == SUB_REQ);
  assign shift_ena  = (fsm_q == SR_REQ);
  assign mix_ena    = (fsm_q == MC_REQ);
  assign ciphertext = ct_q;
  assign ct_valid   = (fsm_q == FIN);

endmodule
